instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 12 +
 rtl/next_pc_calc.sv | 47 ++++
 rtl/instruction_fetch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the PC increment.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC target arithmetic for an accepted instruction.
// Priority: jump_reg > jump > branch_taken > sequential. The result is always word-aligned.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] i_inst_pc,
  input  logic                i_branch_taken,
  input  logic                i_jump,
  input  logic                i_jump_reg,
  input  logic [15:0]         i_branch_imm,
  input  logic [25:0]         i_jump_target,
  input  logic [PC_WIDTH-1:0] i_jr_addr,
  output logic [PC_WIDTH-1:0] o_pc_plus4,
  output logic [PC_WIDTH-1:0] o_next_pc,
  output logic                o_misalign
);

  logic [PC_WIDTH-1:0] w_plus4;
  logic [31:0]         w_plus4_32;
  logic [31:0]         w_br32;
  logic [31:0]         w_jmp32;
  logic [PC_WIDTH-1:0] w_raw;

  // pc_plus4 wraps at PC_WIDTH first, so the jump region bits come from the wrapped value.
  assign w_plus4    = i_inst_pc + PC_WIDTH'(PC_INC);
  assign w_plus4_32 = 32'(w_plus4);
  assign w_br32     = w_plus4_32 + {{14{i_branch_imm[15]}}, i_branch_imm, 2'b00};
  assign w_jmp32    = {w_plus4_32[31:28], i_jump_target, 2'b00};

  always_comb begin
    w_raw = w_plus4;
    if (i_jump_reg) begin
      w_raw = i_jr_addr;
    end else if (i_jump) begin
      w_raw = w_jmp32[PC_WIDTH-1:0];
    end else if (i_branch_taken) begin
      w_raw = w_br32[PC_WIDTH-1:0];
    end
  end

  assign o_pc_plus4 = w_plus4;
  assign o_misalign = |w_raw[1:0];
  assign o_next_pc  = {w_raw[PC_WIDTH-1:2], 2'b00};

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage with decode-side hold, redirects and flush/drain.
// Handshake: an instruction transfers to decode when inst_valid && inst_ready on a rising clk edge.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req,
  output logic [PC_WIDTH-3:0] imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic                jump_reg,
  input  logic [15:0]         branch_imm,
  input  logic [25:0]         jump_target,
  input  logic [PC_WIDTH-1:0] jr_addr,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] flush_pc,
  output logic                misalign,
  output fetch_state_e        state_dbg
);

  fetch_state_e        r_state;
  fetch_state_e        w_next_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_drain_pc;
  logic [31:0]         r_inst;
  logic [PC_WIDTH-1:0] r_inst_pc;
  logic                r_misalign;

  logic                w_accept;
  logic [PC_WIDTH-1:0] w_calc_pc;
  logic                w_calc_mis;
  logic [PC_WIDTH-1:0] w_flush_al;
  logic                w_flush_mis;
  logic                w_set_mis;

  next_pc_calc #(.PC_WIDTH(PC_WIDTH)) u_next_pc_calc (
    .i_inst_pc      (r_inst_pc),
    .i_branch_taken (branch_taken),
    .i_jump         (jump),
    .i_jump_reg     (jump_reg),
    .i_branch_imm   (branch_imm),
    .i_jump_target  (jump_target),
    .i_jr_addr      (jr_addr),
    .o_pc_plus4     (pc_plus4),
    .o_next_pc      (w_calc_pc),
    .o_misalign     (w_calc_mis)
  );

  assign w_accept    = (r_state == ST_HOLD) && inst_ready;
  assign w_flush_al  = {flush_pc[PC_WIDTH-1:2], 2'b00};
  assign w_flush_mis = |flush_pc[1:0];
  assign w_set_mis   = flush ? w_flush_mis : (w_accept && w_calc_mis);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Flush outranks everything; a flush without a response must first drain the old request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (flush) begin
          w_next_state = imem_rvalid ? ST_FETCH : ST_DRAIN;
        end else if (imem_rvalid) begin
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (flush || inst_ready) begin
          w_next_state = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid) begin
          w_next_state = ST_FETCH;
        end
      end
      default: w_next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req   = reset_n && (r_state != ST_HOLD);
    inst_valid = (r_state == ST_HOLD);
    state_dbg  = r_state;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_drain_pc <= RESET_PC;
      r_inst     <= '0;
      r_inst_pc  <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= r_misalign | w_set_mis;
      case (r_state)
        ST_FETCH, ST_DRAIN: begin
          if (flush) begin
            if (imem_rvalid) begin
              r_pc <= w_flush_al;
            end else begin
              r_drain_pc <= w_flush_al;
            end
          end else if (imem_rvalid) begin
            if (r_state == ST_DRAIN) begin
              r_pc <= r_drain_pc;
            end else begin
              r_inst    <= imem_rdata;
              r_inst_pc <= r_pc;
            end
          end
        end
        ST_HOLD: begin
          if (flush) begin
            r_pc <= w_flush_al;
          end else if (inst_ready) begin
            r_pc <= w_calc_pc;
          end
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign imem_addr = r_pc[PC_WIDTH-1:2];
  assign inst      = r_inst;
  assign inst_pc   = r_inst_pc;
  assign misalign  = r_misalign;

endmodule
